// File: rtl/clk_gate_sequencer_if.sv
// clk_gate_sequencer_if: request/enable bundle between domain controllers,
// the sequencer and the gate latches.
// Ports: req (to sequencer), gate_en, ack, busy, active_cnt (from it).
interface clk_gate_sequencer_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  req;
  logic [N-1:0]  gate_en;
  logic [N-1:0]  ack;
  logic          busy;
  logic [CW-1:0] active_cnt;

  modport master (
    output req,
    input  gate_en,
    input  ack,
    input  busy,
    input  active_cnt
  );

  modport slave (
    input  req,
    output gate_en,
    output ack,
    output busy,
    output active_cnt
  );
endinterface

// File: rtl/clk_gate_sequencer.sv
// clk_gate_sequencer: round-robin, budget-limited sequencing of N clock
// gate enables through OFF/WAKE/ON/DRAIN phases.
// Ports: clk, reset (async, active-high), bus (slave side of the
// request/enable interface: req in; gate_en, ack, busy, active_cnt out).
module clk_gate_sequencer #(
  parameter int N         = 4,
  parameter int MAX_ON    = 2,
  parameter int WAKE_CYC  = 3,
  parameter int DRAIN_CYC = 2
) (
  input logic                 clk,
  input logic                 reset,
  clk_gate_sequencer_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(N);
  localparam logic [3:0] WAKE_LD  = 4'(WAKE_CYC - 1);
  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYC - 1);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("clk_gate_sequencer: N must be 2..8");
  end
  if (MAX_ON < 1 || MAX_ON > N) begin : g_bad_max
    $error("clk_gate_sequencer: MAX_ON must be 1..N");
  end
  if (WAKE_CYC < 1 || WAKE_CYC > 15) begin : g_bad_wake
    $error("clk_gate_sequencer: WAKE_CYC must be 1..15");
  end
  if (DRAIN_CYC < 1 || DRAIN_CYC > 15) begin : g_bad_drain
    $error("clk_gate_sequencer: DRAIN_CYC must be 1..15");
  end

  typedef enum logic [1:0] {
    OFF, WAKE, ON, DRAIN
  } st_t;

  st_t           st_q  [N];
  st_t           st_d  [N];
  logic [3:0]    cnt_q [N];
  logic [3:0]    cnt_d [N];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] act_q, act_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= OFF;
        cnt_q[i] <= '0;
      end
      ptr_q <= '0;
      act_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ptr_q <= ptr_d;
      act_q <= act_d;
    end
  end

  always_comb begin
    logic          found;
    logic [PW-1:0] ci;
    logic [CW-1:0] nact;
    found = 1'b0;
    ci    = '0;
    nact  = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        OFF: ;
        WAKE: begin
          if (cnt_q[i] != 4'd0) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end else if (bus.req[i]) begin
            st_d[i] = ON;
          end else begin
            st_d[i]  = DRAIN;
            cnt_d[i] = DRAIN_LD;
          end
        end
        ON: begin
          if (!bus.req[i]) begin
            st_d[i]  = DRAIN;
            cnt_d[i] = DRAIN_LD;
          end
        end
        DRAIN: begin
          if (cnt_q[i] != 4'd0) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end else begin
            st_d[i] = OFF;
          end
        end
      endcase
    end
    // Budget uses registered occupancy, so a slot freed this
    // edge only becomes grantable on the following edge.
    if (int'(act_q) < MAX_ON) begin
      for (int k = 0; k < N; k++) begin
        ci = PW'((int'(ptr_q) + k) % N);
        if (!found && st_q[ci] == OFF && bus.req[ci]) begin
          found     = 1'b1;
          st_d[ci]  = WAKE;
          cnt_d[ci] = WAKE_LD;
          ptr_d     = PW'((int'(ci) + 1) % N);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (st_d[i] != OFF) nact = nact + CW'(1);
    end
    act_d = nact;
  end

  always_comb begin
    bus.gate_en = '0;
    bus.ack     = '0;
    bus.busy    = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.gate_en[i] = (st_q[i] != OFF);
      bus.ack[i]     = (st_q[i] == ON);
      if (st_q[i] == WAKE || st_q[i] == DRAIN)
        bus.busy = 1'b1;
    end
  end

  assign bus.active_cnt = act_q;
endmodule

// File: tb/tb_clk_gate_sequencer.sv
// tb_clk_gate_sequencer: scoreboard bench; a deadline-based phase model
// predicts every post-edge output, a monitor compares after each edge.
module tb_clk_gate_sequencer;
  localparam int N         = 4;
  localparam int MAX_ON    = 2;
  localparam int WAKE_CYC  = 3;
  localparam int DRAIN_CYC = 2;
  localparam int CW        = $clog2(N + 1);

  localparam int P_OFF   = 0;
  localparam int P_WAKE  = 1;
  localparam int P_ON    = 2;
  localparam int P_DRAIN = 3;

  typedef struct {
    logic [N-1:0] g;
    logic [N-1:0] a;
    logic         b;
    int           c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  clk_gate_sequencer_if #(.N(N)) bus ();

  clk_gate_sequencer #(
    .N(N), .MAX_ON(MAX_ON),
    .WAKE_CYC(WAKE_CYC), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   nchk = 0;
  int   nerr = 0;

  // model: phase per channel plus the absolute edge number at
  // which its current phase reaches its decision point
  int ph [N];
  int dl [N];
  int rr = 0;
  int en = 0;

  task automatic chk(input string nm, input int act, input int want);
    nchk++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, want, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r,
                            input logic rs);
    int   nph [N];
    int   used;
    int   c;
    exp_t e;
    en++;
    if (rs) begin
      for (int i = 0; i < N; i++) begin
        ph[i] = P_OFF;
        dl[i] = 0;
      end
      rr = 0;
    end else begin
      used = 0;
      for (int i = 0; i < N; i++) begin
        if (ph[i] != P_OFF) used++;
        nph[i] = ph[i];
      end
      for (int i = 0; i < N; i++) begin
        case (ph[i])
          P_WAKE: if (en == dl[i]) begin
            if (r[i]) nph[i] = P_ON;
            else begin
              nph[i] = P_DRAIN;
              dl[i]  = en + DRAIN_CYC;
            end
          end
          P_ON: if (!r[i]) begin
            nph[i] = P_DRAIN;
            dl[i]  = en + DRAIN_CYC;
          end
          P_DRAIN: if (en == dl[i]) nph[i] = P_OFF;
          default: ;
        endcase
      end
      if (used < MAX_ON) begin
        for (int k = 0; k < N; k++) begin
          c = (rr + k) % N;
          if (ph[c] == P_OFF && r[c]) begin
            nph[c] = P_WAKE;
            dl[c]  = en + WAKE_CYC;
            rr     = (c + 1) % N;
            break;
          end
        end
      end
      for (int i = 0; i < N; i++) ph[i] = nph[i];
    end
    e.g = '0;
    e.a = '0;
    e.b = 1'b0;
    e.c = 0;
    for (int i = 0; i < N; i++) begin
      e.g[i] = (ph[i] != P_OFF);
      e.a[i] = (ph[i] == P_ON);
      if (ph[i] == P_WAKE || ph[i] == P_DRAIN) e.b = 1'b1;
      if (ph[i] != P_OFF) e.c++;
    end
    expq.push_back(e);
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic rs);
    @(negedge clk);
    bus.req = r;
    reset   = rs;
    @(posedge clk);
    model_step(r, rs);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gate_en"}, int'(bus.gate_en), 0);
    chk({tag, "_ack"}, int'(bus.ack), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_active_cnt"}, int'(bus.active_cnt), 0);
  endtask

  task automatic async_reset(input logic [N-1:0] r);
    @(negedge clk);
    #1;
    reset   = 1'b1;
    bus.req = r;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    model_step(r, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("gate_en", int'(bus.gate_en), int'(e.g));
        chk("ack", int'(bus.ack), int'(e.a));
        chk("busy", int'(bus.busy), int'(e.b));
        chk("active_cnt", int'(bus.active_cnt), e.c);
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    bus.req = '0;
    for (int i = 0; i < N; i++) begin
      ph[i] = P_OFF;
      dl[i] = 0;
    end
    #1;
    chk_zero("reset");
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    // single request then release
    repeat (6) cycle(4'b0001, 1'b0);
    repeat (5) cycle(4'b0000, 1'b0);
    // budget: all request, then ch0 releases
    repeat (6) cycle(4'b1111, 1'b0);
    repeat (8) cycle(4'b1110, 1'b0);
    repeat (6) cycle(4'b0000, 1'b0);
    // abort in wake
    cycle(4'b0010, 1'b0);
    repeat (8) cycle(4'b0000, 1'b0);
    // re-request during drain
    repeat (5) cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);
    repeat (10) cycle(4'b0001, 1'b0);
    repeat (6) cycle(4'b0000, 1'b0);
    // randomized level requests
    r = '0;
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) r[i] = ~r[i];
      cycle(r, 1'b0);
    end
    repeat (8) cycle(4'b0000, 1'b0);
    // two channels on, then async reset between edges
    repeat (7) cycle(4'b0011, 1'b0);
    async_reset(4'b0100);
    cycle(4'b0100, 1'b1);
    repeat (6) cycle(4'b0100, 1'b0);
    repeat (6) cycle(4'b0000, 1'b0);
    for (int w = 0; w < 10 && expq.size() > 0; w++)
      @(posedge clk);
    #5;
    if (expq.size() > 0) begin
      nerr++;
      $display("FAIL drain_queue: got %0d pending expected 0",
               expq.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
